// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction FIFO between fetch and decode with one-cycle flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      push_valid,
    input  logic [31:0]               push_pc,
    input  logic [31:0]               push_instr,
    output logic                      push_ready,
    output logic                      deq_valid,
    output logic [31:0]               deq_pc,
    output logic [31:0]               deq_instr,
    input  logic                      deq_ready,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int                 PTR_W     = $clog2(DEPTH);
    localparam int                 CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0]   C_FULL    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]   C_CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0]   C_PTR_ONE = PTR_W'(1);

    logic [31:0]      r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // push_ready deliberately ignores deq_ready: no combinational decode->fetch path.
    assign push_ready = (r_count != C_FULL);
    assign deq_valid  = (r_count != '0);
    assign deq_pc     = deq_valid ? r_mem_pc[r_rd_ptr]    : 32'h0000_0000;
    assign deq_instr  = deq_valid ? r_mem_instr[r_rd_ptr] : NOP_INSTR;
    assign count      = r_count;

    assign w_push = push_valid & push_ready;
    assign w_pop  = deq_ready & deq_valid;

    // Entry storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !rst) begin
            r_mem_pc[r_wr_ptr]    <= push_pc;
            r_mem_instr[r_wr_ptr] <= push_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifndef SYNTHESIS
    // Low count bits always equal the pointer distance; full implies equal pointers.
    always @(posedge clk) begin
        if (!rst) begin
            assert (r_count <= C_FULL);
            assert (r_count[PTR_W-1:0] == PTR_W'(r_wr_ptr - r_rd_ptr));
            assert ((r_count != C_FULL) || (r_wr_ptr == r_rd_ptr));
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Scoreboard bench for fetch_queue with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_pc = '0;
    logic [31:0] push_instr = '0;
    logic        push_ready;
    logic        deq_valid;
    logic [31:0] deq_pc;
    logic [31:0] deq_instr;
    logic        deq_ready = 1'b0;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q [$];

    fetch_queue #(.DEPTH(4), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr),
        .push_ready(push_ready),
        .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_instr(deq_instr),
        .deq_ready(deq_ready), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs for one clock edge; accepted pushes enter the scoreboard.
    task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic dr, input logic fl, input logic acc);
        push_valid = pv;
        push_pc    = pc;
        push_instr = ins;
        deq_ready  = dr;
        flush      = fl;
        if (pv && acc && !fl) exp_q.push_back({pc, ins});
        @(posedge clk);
        #1;
        if (fl) exp_q.delete();
        push_valid = 1'b0;
        deq_ready  = 1'b0;
        flush      = 1'b0;
    endtask

    // Monitor: every head consumed by decode must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && !flush && deq_valid && deq_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h expected none", deq_pc, deq_instr);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({deq_pc, deq_instr} !== e) begin
                    bad++;
                    $display("FAIL pop_order: got pc=%h instr=%h expected pc=%h instr=%h",
                             deq_pc, deq_instr, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_deq_valid", 32'(deq_valid), 32'h0);
        chk("rst_deq_instr", deq_instr, 32'h0000_0013);
        chk("rst_deq_pc", deq_pc, 32'h0);
        chk("rst_push_ready", 32'(push_ready), 32'h1);
        chk("rst_count", 32'(count), 32'h0);

        // Single push: no same-cycle bypass, visible one edge later
        push_valid = 1'b1; push_pc = 32'h6000_0000; push_instr = 32'h0010_0093;
        #1 chk("no_bypass", 32'(deq_valid), 32'h0);
        drive(1'b1, 32'h6000_0000, 32'h0010_0093, 1'b0, 1'b0, 1'b1);
        chk("push1_valid", 32'(deq_valid), 32'h1);
        chk("push1_pc", deq_pc, 32'h6000_0000);
        chk("push1_instr", deq_instr, 32'h0010_0093);
        chk("push1_count", 32'(count), 32'h1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("pop1_count", 32'(count), 32'h0);

        // Fill to DEPTH, refuse the fifth, drain in order
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'h6000_0000 + 32'(4 * i), 32'h0000_1000 + 32'(i), 1'b0, 1'b0, 1'b1);
        chk("full_count", 32'(count), 32'h4);
        chk("full_push_ready", 32'(push_ready), 32'h0);
        drive(1'b1, 32'h6000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        chk("refused_count", 32'(count), 32'h4);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drained_valid", 32'(deq_valid), 32'h0);
        chk("drained_instr", deq_instr, 32'h0000_0013);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("underflow_count", 32'(count), 32'h0);

        // Full with pop in the same cycle: push still refused, pop happens
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'h6000_0020 + 32'(4 * i), 32'h0000_2000 + 32'(i), 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h6000_0030, 32'hBAD0_0000, 1'b1, 1'b0, 1'b0);
        chk("full_pop_count", 32'(count), 32'h3);
        chk("full_pop_head", deq_pc, 32'h6000_0024);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Simultaneous push/pop across the pointer wrap
        drive(1'b1, 32'h6000_0040, 32'h0000_3000, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'h6000_0040 + 32'(4 * i), 32'h0000_3000 + 32'(i), 1'b1, 1'b0, 1'b1);
            chk("wrap_count", 32'(count), 32'h1);
            chk("wrap_head", deq_pc, 32'h6000_0040 + 32'(4 * i));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush with count=3 and a concurrent push that must be dropped
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h6000_0080 + 32'(4 * i), 32'h0000_4000 + 32'(i), 1'b0, 1'b0, 1'b1);
        chk("preflush_count", 32'(count), 32'h3);
        drive(1'b1, 32'h6000_0100, 32'h0000_5000, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_valid", 32'(deq_valid), 32'h0);
        drive(1'b1, 32'h6000_0200, 32'h0000_6000, 1'b0, 1'b0, 1'b1);
        chk("postflush_pc", deq_pc, 32'h6000_0200);
        chk("postflush_count", 32'(count), 32'h1);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 2; i++)
            drive(1'b1, 32'h6000_0300 + 32'(4 * i), 32'h0000_7000 + 32'(i), 1'b0, 1'b0, 1'b1);
        chk("prereset_count", 32'(count), 32'h2);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(deq_valid), 32'h0);
        chk("async_rst_count", 32'(count), 32'h0);
        chk("async_rst_instr", deq_instr, 32'h0000_0013);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b1, 32'h6000_0000, 32'h0010_0093, 1'b0, 1'b0, 1'b1);
        chk("after_rst_count", 32'(count), 32'h1);
        chk("after_rst_pc", deq_pc, 32'h6000_0000);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
